// File: rtl/boot_fetch_ctrl.sv
// boot_fetch_ctrl: streams a program image into memory, then
// issues sequential fetches and hands aligned insn/pc to decode.
module boot_fetch_ctrl #(
  parameter int unsigned       ADDR_W        = 32,
  parameter int unsigned       DATA_W        = 32,
  parameter logic [ADDR_W-1:0] START_ADDRESS = 32'h80020000,
  parameter int unsigned       MAX_WORDS     = 1024,
  parameter int unsigned       READ_LATENCY  = 1,
  localparam int unsigned      CNT_W         = $clog2(MAX_WORDS + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              mem_enable,
  output logic [1:0]        mem_acc_size,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] insn,
  output logic [ADDR_W-1:0] pc,
  output logic              insn_valid,
  output logic [CNT_W-1:0]  word_count,
  output logic              fetch_done
);

  localparam int unsigned LAT   = READ_LATENCY;
  localparam int unsigned DEPTH = LAT + 1;
  localparam int unsigned OC_W  = $clog2(2 * DEPTH + 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_FETCH,
    S_END
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  wc_q, wc_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;

  logic              men_q, men_d;
  logic              mwr_q, mwr_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] mwd_q, mwd_d;

  logic [LAT-1:0]    fv_q, fv_d;
  logic [ADDR_W-1:0] fpcs_q [LAT];
  logic [ADDR_W-1:0] fpcs_d [LAT];

  logic [DATA_W-1:0] qd_q [DEPTH];
  logic [DATA_W-1:0] qd_d [DEPTH];
  logic [ADDR_W-1:0] qp_q [DEPTH];
  logic [ADDR_W-1:0] qp_d [DEPTH];
  logic [OC_W-1:0]   qc_q, qc_d;

  logic              ov_q, ov_d;
  logic [DATA_W-1:0] oi_q, oi_d;
  logic [ADDR_W-1:0] op_q, op_d;

  logic              accept;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] off;
  logic              in_range;
  logic [OC_W-1:0]   n_fly;
  logic              push;
  logic              q_pop;
  logic              room;
  logic              flush;
  logic              issue;

  assign load_ready = reset_n
                    & (state_q == S_LOAD)
                    & ~mem_busy;
  assign accept     = load_valid & load_ready;

  assign span     = ADDR_W'({wc_q, 2'b00});
  assign off      = fpc_q - START_ADDRESS;
  assign in_range = (fpc_q[1:0] == 2'b00) && (off < span);

  // Count reads still travelling through the memory pipe
  always_comb begin
    n_fly = '0;
    for (int i = 0; i < LAT; i++) begin
      n_fly = n_fly + OC_W'(fv_q[i]);
    end
  end

  assign push  = fv_q[LAT-1];
  assign q_pop = (qc_q != '0) && (!ov_q || !stall);
  assign room  = (qc_q + n_fly - OC_W'(q_pop))
               < OC_W'(DEPTH);
  assign flush = (state_q == S_FETCH) && redirect;
  assign issue = (state_q == S_FETCH) && !redirect
              && in_range && !mem_busy && room;

  // Sequencer: next state, load writes and fetch issue
  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    fpc_d   = fpc_q;
    men_d   = 1'b0;
    mwr_d   = 1'b0;
    maddr_d = maddr_q;
    mwd_d   = mwd_q;
    unique case (state_q)
      S_LOAD: begin
        fpc_d = START_ADDRESS;
        if (accept) begin
          men_d   = 1'b1;
          mwr_d   = 1'b1;
          maddr_d = START_ADDRESS
                  + ADDR_W'({wc_q, 2'b00});
          mwd_d   = load_data;
          wc_d    = wc_q + CNT_W'(1);
          if (load_last ||
              wc_q == CNT_W'(MAX_WORDS - 1)) begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (redirect) begin
          fpc_d = redirect_pc;
        end else if (issue) begin
          men_d   = 1'b1;
          maddr_d = fpc_q;
          fpc_d   = fpc_q + ADDR_W'(4);
        end else if (!in_range && n_fly == '0 &&
                     qc_q == '0 && !ov_q) begin
          state_d = S_END;
        end
      end
      S_END: begin
      end
      default: state_d = S_LOAD;
    endcase
  end

  // In-flight read pipe tracking valid bit and pc per read
  always_comb begin
    fv_d      = '0;
    fpcs_d[0] = fpc_q;
    fv_d[0]   = issue;
    for (int i = 1; i < LAT; i++) begin
      fv_d[i]   = fv_q[i-1];
      fpcs_d[i] = fpcs_q[i-1];
    end
    if (flush) begin
      fv_d = '0;
    end
  end

  // Shift FIFO catching returned read data
  always_comb begin
    qc_d = qc_q;
    for (int i = 0; i < DEPTH; i++) begin
      qd_d[i] = qd_q[i];
      qp_d[i] = qp_q[i];
    end
    if (q_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        qd_d[i] = qd_q[i+1];
        qp_d[i] = qp_q[i+1];
      end
      qc_d = qc_q - OC_W'(1);
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (OC_W'(i) == qc_d) begin
          qd_d[i] = mem_rdata;
          qp_d[i] = fpcs_q[LAT-1];
        end
      end
      qc_d = qc_d + OC_W'(1);
    end
    if (flush) begin
      qc_d = '0;
    end
  end

  // Decode-facing register, held while decode stalls
  always_comb begin
    ov_d = ov_q;
    oi_d = oi_q;
    op_d = op_q;
    if (flush) begin
      ov_d = 1'b0;
    end else if (q_pop) begin
      ov_d = 1'b1;
      oi_d = qd_q[0];
      op_d = qp_q[0];
    end else if (ov_q && !stall) begin
      ov_d = 1'b0;
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_LOAD;
      wc_q    <= '0;
      fpc_q   <= START_ADDRESS;
      men_q   <= 1'b0;
      mwr_q   <= 1'b0;
      maddr_q <= START_ADDRESS;
      mwd_q   <= '0;
      fv_q    <= '0;
      qc_q    <= '0;
      ov_q    <= 1'b0;
      oi_q    <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      fpc_q   <= fpc_d;
      men_q   <= men_d;
      mwr_q   <= mwr_d;
      maddr_q <= maddr_d;
      mwd_q   <= mwd_d;
      fv_q    <= fv_d;
      qc_q    <= qc_d;
      ov_q    <= ov_d;
      oi_q    <= oi_d;
      op_q    <= op_d;
    end
  end

  // Payload storage, qualified by the valid/count state above
  always_ff @(posedge clock) begin
    fpcs_q <= fpcs_d;
    qd_q   <= qd_d;
    qp_q   <= qp_d;
  end

  assign mem_addr     = maddr_q;
  assign mem_wdata    = mwd_q;
  assign mem_wren     = mwr_q;
  assign mem_enable   = men_q;
  assign mem_acc_size = 2'b00;
  assign insn         = oi_q;
  assign pc           = op_q;
  assign insn_valid   = ov_q;
  assign word_count   = wc_q;
  assign fetch_done   = (state_q == S_END);

endmodule

// File: tb/tb_boot_fetch_ctrl.sv
// tb_boot_fetch_ctrl: random load/fetch traffic against a
// queue-based reference of the loaded image and fetch order.
module tb_boot_fetch_ctrl;

  localparam int          LAT   = 3;
  localparam int          MAXW  = 8;
  localparam logic [31:0] START = 32'h80020000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } pair_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wren;
  logic        mem_enable;
  logic [1:0]  mem_acc_size;
  logic        mem_busy = 1'b0;
  logic [31:0] mem_rdata;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] insn;
  logic [31:0] pc;
  logic        insn_valid;
  logic [3:0]  word_count;
  logic        fetch_done;

  int    n_chk = 0;
  int    n_fail = 0;
  bit    mon_en = 0;
  pair_t exp_wr[$];
  pair_t exp_ins[$];
  logic [31:0] img[$];

  logic [31:0] mem_arr [256];
  logic [31:0] rd0, rd1;

  boot_fetch_ctrl #(
    .ADDR_W(32),
    .DATA_W(32),
    .START_ADDRESS(START),
    .MAX_WORDS(MAXW),
    .READ_LATENCY(LAT)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_last(load_last),
    .load_ready(load_ready),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wren(mem_wren),
    .mem_enable(mem_enable),
    .mem_acc_size(mem_acc_size),
    .mem_busy(mem_busy),
    .mem_rdata(mem_rdata),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .insn(insn),
    .pc(pc),
    .insn_valid(insn_valid),
    .word_count(word_count),
    .fetch_done(fetch_done)
  );

  always #5 clock = ~clock;

  // Memory: data for a request shows up LAT-1 cycles later
  always @(posedge clock) begin
    rd0 <= mem_arr[mem_addr[9:2]];
    rd1 <= rd0;
    if (mem_enable && mem_wren) begin
      mem_arr[mem_addr[9:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = rd1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit in_img(input logic [31:0] a);
    logic [31:0] o;
    o = a - START;
    return (a[1:0] == 2'b00) && (o < 32'(4 * img.size()));
  endfunction

  // Monitor: scoreboard pops for writes and consumed insns
  initial begin
    bit          hp;
    logic [31:0] hi, hpc;
    hp = 0;
    forever begin
      @(negedge clock);
      if (!mon_en) begin
        hp = 0;
      end else begin
        if (mem_enable && mem_wren) begin
          chk("write_expected", exp_wr.size() != 0, 1);
          if (exp_wr.size() != 0) begin
            pair_t w;
            w = exp_wr.pop_front();
            chk("write_addr", mem_addr, w.a);
            chk("write_data", mem_wdata, w.d);
          end
        end
        if (hp) begin
          chk("hold_valid", insn_valid, 1);
          chk("hold_insn", insn, hi);
          chk("hold_pc", pc, hpc);
        end
        hp  = insn_valid && stall && !redirect;
        hi  = insn;
        hpc = pc;
        if (insn_valid && !stall && !redirect) begin
          chk("insn_expected", exp_ins.size() != 0, 1);
          if (exp_ins.size() != 0) begin
            pair_t e;
            e = exp_ins.pop_front();
            chk("insn_pc", pc, e.a);
            chk("insn_data", insn, e.d);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clock); #1;
    mon_en     = 0;
    reset_n    = 0;
    load_valid = 0;
    load_last  = 0;
    mem_busy   = 0;
    stall      = 0;
    redirect   = 0;
    exp_wr.delete();
    exp_ins.delete();
    @(posedge clock);
    @(negedge clock);
    chk("rst_word_count", word_count, 0);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_mem_wren", mem_wren, 0);
    chk("rst_mem_enable", mem_enable, 0);
    chk("rst_mem_addr", mem_addr, START);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_acc_size", mem_acc_size, 0);
    chk("rst_insn", insn, 0);
    chk("rst_pc", pc, 0);
    chk("rst_insn_valid", insn_valid, 0);
    chk("rst_fetch_done", fetch_done, 0);
    @(posedge clock); #1;
    reset_n = 1;
    @(negedge clock);
    chk("post_rst_ready", load_ready, 1);
    chk("post_rst_count", word_count, 0);
    mon_en = 1;
  endtask

  task automatic load_image(input bit use_last,
                            input int busy_pct,
                            input int gap_pct,
                            input int force_busy);
    int i, fb, guard, n;
    bit fin;
    n = img.size();
    i = 0; fb = 0; guard = 0; fin = 0;
    while (!fin && guard < 500) begin
      @(posedge clock); #1;
      if (i == force_busy && fb < 3) begin
        mem_busy   = 1;
        load_valid = 1;
        fb++;
      end else begin
        mem_busy   = ($urandom_range(99) < busy_pct);
        load_valid = ($urandom_range(99) >= gap_pct);
      end
      load_data = img[i];
      load_last = use_last && (i == n - 1);
      @(negedge clock);
      chk("load_ready", load_ready, !mem_busy);
      if (load_valid && !mem_busy) begin
        exp_wr.push_back('{a: START + 32'(4 * i), d: img[i]});
        i++;
        if (load_last || i == MAXW) fin = 1;
      end
      guard++;
    end
    chk("load_done", fin, 1);
    @(posedge clock); #1;
    load_valid = 0;
    load_last  = 0;
    mem_busy   = 0;
    @(negedge clock);
    chk("word_count", word_count, n);
    chk("ready_after_load", load_ready, 0);
    @(negedge clock);
    chk("first_issue_en", mem_enable, 1);
    chk("first_issue_wr", mem_wren, 0);
    chk("first_issue_addr", mem_addr, START);
    for (int k = 0; k < n; k++) begin
      exp_ins.push_back('{a: START + 32'(4 * k), d: img[k]});
    end
  endtask

  task automatic run_fetch(input int stall_pct,
                           input int busy_pct,
                           input int hold_first,
                           input int redir_after,
                           input logic [31:0] rpc,
                           input int budget,
                           input bit expect_done);
    int cyc, rcyc, scyc, hold;
    bit seen, done, oor;
    cyc = 0; rcyc = -1; scyc = 0; hold = hold_first;
    seen = 0; done = 0;
    oor = !in_img(rpc);
    while (cyc < budget && !done) begin
      @(posedge clock); #1;
      if (hold_first > 0 && (!seen || hold > 0)) begin
        stall = 1;
        if (seen) hold--;
      end else begin
        stall = ($urandom_range(99) < stall_pct);
      end
      mem_busy = ($urandom_range(99) < busy_pct);
      redirect = 0;
      if (redir_after >= 0 && seen && rcyc < 0 &&
          cyc >= scyc + 1 + redir_after) begin
        redirect    = 1;
        redirect_pc = rpc;
        rcyc        = cyc;
        exp_ins.delete();
        for (logic [31:0] a = rpc; in_img(a); a += 4) begin
          exp_ins.push_back('{a: a, d: img[(a - START) >> 2]});
        end
      end
      @(negedge clock);
      if (!seen && insn_valid) begin
        seen = 1;
        scyc = cyc;
      end
      if (rcyc >= 0 && cyc > rcyc && oor) begin
        chk("no_issue_after_redir", mem_enable, 0);
      end
      if (fetch_done) begin
        done = 1;
      end else begin
        cyc++;
      end
    end
    if (expect_done) begin
      chk("fetch_done_in_budget", done, 1);
      if (rcyc >= 0 && oor) begin
        chk("done_latency", (cyc - rcyc) <= LAT + 2, 1);
      end
      chk("all_insns_seen", exp_ins.size(), 0);
      chk("all_writes_seen", exp_wr.size(), 0);
      chk("end_insn_valid", insn_valid, 0);
      chk("end_mem_enable", mem_enable, 0);
    end
    @(posedge clock); #1;
    stall    = 0;
    mem_busy = 0;
    redirect = 0;
  endtask

  task automatic rand_img(input int n);
    img.delete();
    for (int k = 0; k < n; k++) img.push_back($urandom);
  endtask

  initial begin
    do_reset();

    img = '{32'h20020005, 32'h20030007,
            32'h00432020, 32'h00000000};
    load_image(1, 0, 0, 1);
    run_fetch(0, 0, 5, -1, 32'h0, 200, 1);

    do_reset();
    rand_img(6);
    load_image(1, 20, 20, -1);
    run_fetch(20, 20, 0, 0, START + 32'h4, 400, 1);

    do_reset();
    rand_img(5);
    load_image(1, 0, 0, -1);
    run_fetch(0, 0, 0, 1, 32'h80030000, 200, 1);

    do_reset();
    rand_img(4);
    load_image(1, 0, 0, -1);
    run_fetch(0, 0, 0, 0, START + 32'h2, 200, 1);

    do_reset();
    rand_img(7);
    load_image(1, 0, 0, -1);
    run_fetch(10, 10, 0, -1, 32'h0, 8, 0);
    do_reset();

    rand_img(MAXW);
    load_image(0, 10, 10, -1);
    run_fetch(30, 10, 0, -1, 32'h0, 400, 1);

    for (int r = 0; r < 4; r++) begin
      do_reset();
      rand_img($urandom_range(1, MAXW));
      load_image(1, 25, 25, -1);
      run_fetch(40, 25, 0, -1, 32'h0, 600, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
